// File: rtl/spawn_position_scheduler_if.sv
// Request/ack, RNG and occupancy-query signals shared by the spawn scheduler and its neighbours.
// The slave modport is the scheduler's view; master is the game/RNG/board side.
interface spawn_position_scheduler_if;
  logic       apple_req;
  logic       wall_req;
  logic       apple_ack;
  logic       wall_ack;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic       pos_fail;
  logic       rng_enable;
  logic [7:0] rng_number;
  logic [3:0] occ_x;
  logic [3:0] occ_y;
  logic       occ_hit;
  logic       busy;

  modport slave (
    input  apple_req, wall_req, rng_number, occ_hit,
    output apple_ack, wall_ack, pos_x, pos_y, pos_fail, rng_enable, occ_x, occ_y, busy
  );

  modport master (
    output apple_req, wall_req, rng_number, occ_hit,
    input  apple_ack, wall_ack, pos_x, pos_y, pos_fail, rng_enable, occ_x, occ_y, busy
  );
endinterface

// File: rtl/spawn_position_scheduler.sv
// Arbitrates the wall-mode RNG between apple and wall spawn requests, drawing candidate
// cells until one is on-grid and unoccupied or the try budget is exhausted.
module spawn_position_scheduler #(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 12,
  parameter int unsigned RNG_WAIT  = 2,
  parameter int unsigned MAX_TRIES = 15
) (
  input logic                         system_clk,
  input logic                         reset,
  spawn_position_scheduler_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, STEP, WAIT, CHECK, DONE} state_t;
  typedef enum logic {SIDE_APPLE, SIDE_WALL} side_t;

  state_t     state;
  side_t      grant;
  side_t      pref;
  logic [7:0] tries;
  logic [7:0] wait_cnt;
  logic [3:0] cand_x;
  logic [3:0] cand_y;
  logic [3:0] pos_x_r;
  logic [3:0] pos_y_r;
  logic       pos_fail_r;
  logic       apple_ack_r;
  logic       wall_ack_r;
  logic       rng_en_r;
  logic       busy_r;

  logic granted_req;
  logic in_bounds;
  logic legal;

  // Out-of-bounds candidates are illegal regardless of occ_hit.
  always_comb begin
    granted_req = (grant == SIDE_APPLE) ? bus.apple_req : bus.wall_req;
    in_bounds   = ({1'b0, cand_x} < 5'(GRID_W)) && ({1'b0, cand_y} < 5'(GRID_H));
    legal       = in_bounds && !bus.occ_hit;
  end

  always_ff @(posedge system_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= SIDE_APPLE;
      pref        <= SIDE_APPLE;
      tries       <= '0;
      wait_cnt    <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      pos_x_r     <= '0;
      pos_y_r     <= '0;
      pos_fail_r  <= 1'b0;
      apple_ack_r <= 1'b0;
      wall_ack_r  <= 1'b0;
      rng_en_r    <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      rng_en_r    <= 1'b0;
      apple_ack_r <= 1'b0;
      wall_ack_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.apple_req || bus.wall_req) begin
            if (bus.apple_req && (!bus.wall_req || pref == SIDE_APPLE)) begin
              grant <= SIDE_APPLE;
              pref  <= SIDE_WALL;
            end else begin
              grant <= SIDE_WALL;
              pref  <= SIDE_APPLE;
            end
            tries    <= '0;
            state    <= STEP;
            busy_r   <= 1'b1;
            rng_en_r <= 1'b1;
          end
        end
        STEP: begin
          if (!granted_req) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else begin
            tries    <= tries + 8'd1;
            wait_cnt <= 8'(RNG_WAIT - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!granted_req) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (wait_cnt == '0) begin
            cand_x <= bus.rng_number[7:4];
            cand_y <= bus.rng_number[3:0];
            state  <= CHECK;
          end else begin
            wait_cnt <= wait_cnt - 8'd1;
          end
        end
        CHECK: begin
          if (!granted_req) begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end else if (!legal && tries < 8'(MAX_TRIES)) begin
            state    <= STEP;
            rng_en_r <= 1'b1;
          end else begin
            pos_x_r     <= cand_x;
            pos_y_r     <= cand_y;
            pos_fail_r  <= !legal;
            apple_ack_r <= (grant == SIDE_APPLE);
            wall_ack_r  <= (grant == SIDE_WALL);
            state       <= DONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.apple_ack  = apple_ack_r;
  assign bus.wall_ack   = wall_ack_r;
  assign bus.pos_x      = pos_x_r;
  assign bus.pos_y      = pos_y_r;
  assign bus.pos_fail   = pos_fail_r;
  assign bus.rng_enable = rng_en_r;
  assign bus.occ_x      = cand_x;
  assign bus.occ_y      = cand_y;
  assign bus.busy       = busy_r;

endmodule

// File: doc/spawn_position_scheduler.md
Name: spawn_position_scheduler

Overview:
- Shares the game's wall-mode random number generator between two requesters, apple spawn and wall spawn.
- Sequences the generator's enable input and samples its 8-bit output, split as x = bits [7:4] and y = bits [3:0].
- Rejects coordinates that are off-grid or already occupied, and retries until a legal cell is found or the try budget runs out.
- Sits between the game FSM, the RNG and the board occupancy map.

Parameters:
- GRID_W, 16, number of legal x columns (1..16); legal x is 0..GRID_W-1.
- GRID_H, 12, number of legal y rows (1..16); legal y is 0..GRID_H-1.
- RNG_WAIT, 2, cycles to wait after raising rng_enable before sampling rng_number (≥1).
- MAX_TRIES, 15, candidate draws per request before reporting failure (1..255).

Ports:
- system_clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- apple_req  in  1  apple spawn request; level, held until apple_ack.
- wall_req  in  1  wall spawn request; level, held until wall_ack.
- apple_ack  out  1  one-cycle completion pulse for apple.
- wall_ack  out  1  one-cycle completion pulse for wall.
- pos_x  out  4  result x; valid while an ack is high.
- pos_y  out  4  result y; valid while an ack is high.
- pos_fail  out  1  with an ack: no legal cell found in MAX_TRIES draws.
- rng_enable  out  1  RNG update strobe; high for exactly 1 cycle per draw.
- rng_number  in  8  RNG output; x = [7:4], y = [3:0].
- occ_x  out  4  occupancy query x (the registered candidate).
- occ_y  out  4  occupancy query y (the registered candidate).
- occ_hit  in  1  combinational response: the queried cell holds snake, wall or apple.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high): state = IDLE; all outputs 0; try counter, wait counter and candidate registers 0; round-robin pointer = APPLE-first.
- States: IDLE, STEP, WAIT, CHECK, DONE.
- IDLE:
  - If either request is high, grant one and go to STEP; busy rises the next cycle.
  - If both are high, grant the side that was not granted last; after reset, apple wins.
  - On grant, the pointer flips to the other side and the try counter clears.
- STEP:
  - rng_enable = 1 for this single cycle; try counter increments.
  - Next state is WAIT, with the wait counter loaded to RNG_WAIT-1.
- WAIT:
  - Counts down; when it reaches 0, register rng_number into the candidate and go to CHECK.
  - Total from STEP entry to CHECK entry is RNG_WAIT+1 cycles.
- CHECK:
  - occ_x/occ_y show the candidate.
  - The candidate is legal when x < GRID_W, y < GRID_H and occ_hit = 0.
  - Legal: go to DONE with fail = 0.
  - Illegal and try counter < MAX_TRIES: return to STEP.
  - Illegal and try counter = MAX_TRIES: go to DONE with fail = 1.
  - occ_hit is ignored for out-of-bounds candidates; they are always illegal.
- DONE:
  - Exactly one cycle; the granted side's ack = 1.
  - pos_x/pos_y hold the last candidate; pos_fail is set as decided in CHECK.
  - Next state is IDLE.
  - pos_x/pos_y/pos_fail hold their values until the next DONE.
- Minimum latency, grant to ack, first draw legal: STEP + RNG_WAIT + CHECK + DONE = RNG_WAIT+3 cycles after leaving IDLE.
- Request withdrawal: if the granted request drops in any state other than IDLE, the block aborts to IDLE on the next edge. No ack is issued; the pointer keeps its flipped value.
- The non-granted request waits; it is serviced on the cycle after DONE returns to IDLE, with no starvation under constant contention.
- Ack never coincides with rng_enable. Only one ack is ever high at a time.
- Try counter width is 8 bits; no wrap, because MAX_TRIES ≤ 255.
- Reset asserted mid-sequence: immediate return to IDLE, and all outputs clear asynchronously.

Test Plan:
- Apple only, RNG_WAIT=2, rng_number=0x35, occ_hit=0 -> rng_enable pulses once; apple_ack after 5 cycles from leaving IDLE; pos=(3,5); pos_fail=0.
- Wall request, first sample 0xF2 (x=15 ≥ GRID_W=12 in this run), second 0x4A -> two rng_enable pulses; wall_ack with pos=(4,10).
- occ_hit forced 1, MAX_TRIES=3 -> exactly 3 rng_enable pulses, then apple_ack with pos_fail=1.
- Both requests held high from reset -> grant order apple, wall, apple, wall across four completions; acks never overlap.
- Apple request dropped during WAIT -> returns to IDLE; no apple_ack; busy falls; a later wall request is serviced normally.
- Reset asserted during CHECK -> all outputs 0 in the same cycle; after release the block is in IDLE and the next request wins per the reset pointer (apple).
